// File: rtl/cf_fft_reorder_pingpong_rd_if.sv
// Stream bundle for the FFT input reorder buffer: natural-order input, reordered output.
// slave is the buffer's view; master is the upstream/downstream driver's view.
interface cf_fft_reorder_pingpong_rd_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              out_sof;
    logic              out_eof;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eof
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eof
    );
endinterface

// File: rtl/cf_fft_reorder_pingpong_rd.sv
// Ping-pong frame buffer: frames written in natural order, read back from the other bank.
// Define CF_FFT_REORDER_BITREV_EN for bit-reversed read order; undefined gives natural order.
module cf_fft_reorder_pingpong_rd #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic clock_c,
    input  logic reset_n,
    input  logic clr,
    cf_fft_reorder_pingpong_rd_if.slave bus
);
    localparam int N = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    logic [DATA_W-1:0] mem [0:1][0:N-1];

    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rd_word;
    logic              wr_fire;
    logic              wr_last;
    logic              ld;
    logic              rd_last;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_sof_q;
    logic              out_eof_q;

    assign bus.in_ready  = ~full[wr_bank];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;

    assign wr_fire = bus.in_valid & ~full[wr_bank] & ~clr;
    assign wr_last = (wr_cnt == CNT_LAST);
    assign ld      = full[rd_bank] & (~out_valid_q | bus.out_ready);
    assign rd_last = (rd_cnt == CNT_LAST);

`ifdef CF_FFT_REORDER_BITREV_EN
    for (genvar i = 0; i < ADDR_W; i++) begin : g_rev
        assign raddr[i] = rd_cnt[ADDR_W-1-i];
    end
`else
    assign raddr = rd_cnt;
`endif

    assign rd_word = mem[rd_bank][raddr];

    // Storage is deliberately unreset; banks are only read once marked full.
    always_ff @(posedge clock_c) begin
        if (wr_fire) begin
            mem[wr_bank][wr_cnt] <= bus.in_data;
        end
    end

    // The write bank is never full and the read bank is always full when either
    // side completes a frame, so both flag updates can land in the same cycle.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_last) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (ld && rd_last) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clock_c or negedge reset_n) begin
        if (!reset_n) begin
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else if (clr) begin
            full        <= '0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (ld) begin
                out_data_q  <= rd_word;
                out_valid_q <= 1'b1;
                out_sof_q   <= (rd_cnt == '0);
                out_eof_q   <= rd_last;
                rd_cnt      <= rd_cnt + 1'b1;
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
                out_sof_q   <= 1'b0;
                out_eof_q   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cf_fft_reorder_pingpong_rd.sv
// Bench for cf_fft_reorder_pingpong_rd: random and ramp frames against a frame-level queue model.
// The expected read order follows CF_FFT_REORDER_BITREV_EN in the same way as the design build.
module tb_cf_fft_reorder_pingpong_rd;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int N      = 1 << ADDR_W;

    logic clock_c = 1'b0;
    logic reset_n = 1'b0;
    logic clr     = 1'b0;

    cf_fft_reorder_pingpong_rd_if #(.DATA_W(DATA_W)) bus();

    cf_fft_reorder_pingpong_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dut (
        .clock_c (clock_c),
        .reset_n (reset_n),
        .clr     (clr),
        .bus     (bus.slave)
    );

    always #5 clock_c = ~clock_c;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              sof;
        logic              eof;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] part_q[$];

    // Position within the stored frame that is emitted as the k-th output.
    function automatic int perm(input int k);
        int r;
        r = k;
`ifdef CF_FFT_REORDER_BITREV_EN
        r = 0;
        for (int i = 0; i < ADDR_W; i++) begin
            r = (r * 2) + ((k >> i) & 1);
        end
`endif
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        part_q.delete();
    endtask

    // One clock: observe outputs at the falling edge, drive inputs, advance the model.
    task automatic do_cycle(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                            input logic iclr, output logic rdy, output logic ov,
                            output logic [DATA_W-1:0] od, output logic osof, output logic oeof);
        @(negedge clock_c);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        clr           = iclr;
        rdy  = bus.in_ready;
        ov   = bus.out_valid;
        od   = bus.out_data;
        osof = bus.out_sof;
        oeof = bus.out_eof;
        if (iclr) begin
            model_reset();
        end else if (iv && rdy) begin
            part_q.push_back(id);
            if (part_q.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    exp_q.push_back('{d: part_q[perm(k)], sof: (k == 0), eof: (k == N-1)});
                end
                part_q.delete();
            end
        end
        @(posedge clock_c);
    endtask

    task automatic test_reset();
        @(negedge clock_c);
        n_cmp++;
        if ({bus.out_valid, bus.out_sof, bus.out_eof} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got v/sof/eof=%b%b%b required 000",
                     bus.out_valid, bus.out_sof, bus.out_eof);
        end
        n_cmp++;
        if (bus.out_data !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 0", bus.out_data);
        end
        reset_n = 1'b1;
        @(negedge clock_c);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
    endtask

    task automatic test_ramp();
        logic rdy, ov, osof, oeof;
        logic [DATA_W-1:0] od;
        exp_t e;
        int acc = 0;
        int outs = 0;
        for (int c = 0; c < 2*N && acc < N; c++) begin
            do_cycle(1'b1, DATA_W'(acc), 1'b1, 1'b0, rdy, ov, od, osof, oeof);
            n_cmp++;
            if (rdy !== 1'b1 || ov !== 1'b0) begin
                n_err++;
                $display("FAIL ramp_fill[%0d]: got ready=%b valid=%b required 1/0", acc, rdy, ov);
            end
            if (rdy) acc++;
        end
        do_cycle(1'b0, '0, 1'b1, 1'b0, rdy, ov, od, osof, oeof);
        n_cmp++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_latency_early: got valid=%b required 0", ov);
        end
        for (int c = 0; c < 2*N && exp_q.size() > 0; c++) begin
            do_cycle(1'b0, '0, 1'b1, 1'b0, rdy, ov, od, osof, oeof);
            if (c == 0) begin
                n_cmp++;
                if (ov !== 1'b1 || osof !== 1'b1 || od !== '0) begin
                    n_err++;
                    $display("FAIL ramp_first: got valid=%b sof=%b data=%h required 1/1/0", ov, osof, od);
                end
            end
            if (ov) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({od, osof, oeof} !== {e.d, e.sof, e.eof}) begin
                    n_err++;
                    $display("FAIL ramp_out[%0d]: got %h sof=%b eof=%b required %h sof=%b eof=%b",
                             outs, od, osof, oeof, e.d, e.sof, e.eof);
                end
                outs++;
            end
        end
        do_cycle(1'b0, '0, 1'b1, 1'b0, rdy, ov, od, osof, oeof);
        n_cmp++;
        if (outs != N || ov !== 1'b0) begin
            n_err++;
            $display("FAIL ramp_count: got %0d outputs trailing valid=%b required %0d/0", outs, ov, N);
        end
    endtask

    task automatic test_backpressure();
        logic rdy, ov, osof, oeof, prev_rdy, seen_eof;
        logic [DATA_W-1:0] od;
        exp_t e;
        int acc = 0;
        for (int c = 0; c < 3*N; c++) begin
            do_cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0, rdy, ov, od, osof, oeof);
            if (rdy) acc++;
        end
        n_cmp++;
        if (acc != 2*N || rdy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_capacity: got %0d accepts ready=%b required %0d/0", acc, rdy, 2*N);
        end
        prev_rdy = rdy;
        seen_eof = 1'b0;
        for (int c = 0; c < 8*N && (acc < 3*N || exp_q.size() > 0); c++) begin
            do_cycle(acc < 3*N, DATA_W'($urandom), 1'b1, 1'b0, rdy, ov, od, osof, oeof);
            if (acc < 3*N && rdy) acc++;
            if (ov && oeof && !seen_eof) begin
                seen_eof = 1'b1;
                n_cmp++;
                if (rdy !== 1'b1 || prev_rdy !== 1'b0) begin
                    n_err++;
                    $display("FAIL bp_ready_return: got before/after=%b/%b required 0/1", prev_rdy, rdy);
                end
            end
            if (ov) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL bp_out: got unexpected %h required no output", od);
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({od, osof, oeof} !== {e.d, e.sof, e.eof}) begin
                        n_err++;
                        $display("FAIL bp_out: got %h sof=%b eof=%b required %h sof=%b eof=%b",
                                 od, osof, oeof, e.d, e.sof, e.eof);
                    end
                end
            end
            prev_rdy = rdy;
        end
        n_cmp++;
        if (acc != 3*N || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_drain: got %0d accepts %0d pending required %0d/0", acc, exp_q.size(), 3*N);
        end
    endtask

    task automatic test_toggle();
        logic rdy, ov, osof, oeof, ordy, hold;
        logic [DATA_W-1:0] od;
        logic [DATA_W+1:0] prev;
        exp_t e;
        int acc = 0;
        int outs = 0;
        hold = 1'b0;
        prev = '0;
        for (int c = 0; c < 6*N && (acc < N || exp_q.size() > 0); c++) begin
            ordy = ~c[0];
            do_cycle(acc < N, DATA_W'($urandom), ordy, 1'b0, rdy, ov, od, osof, oeof);
            if (acc < N && rdy) acc++;
            if (hold) begin
                n_cmp++;
                if (ov !== 1'b1 || {od, osof, oeof} !== prev) begin
                    n_err++;
                    $display("FAIL toggle_hold: got v=%b %h required 1 %h", ov, {od, osof, oeof}, prev);
                end
            end
            if (ov && ordy) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({od, osof, oeof} !== {e.d, e.sof, e.eof}) begin
                    n_err++;
                    $display("FAIL toggle_out[%0d]: got %h sof=%b eof=%b required %h sof=%b eof=%b",
                             outs, od, osof, oeof, e.d, e.sof, e.eof);
                end
                outs++;
            end
            hold = ov & ~ordy;
            prev = {od, osof, oeof};
        end
        n_cmp++;
        if (outs != N) begin
            n_err++;
            $display("FAIL toggle_count: got %0d required %0d", outs, N);
        end
    endtask

    task automatic test_random_frames();
        logic rdy, ov, osof, oeof, started;
        logic [DATA_W-1:0] od;
        exp_t e;
        int acc = 0;
        int gaps = 0;
        started = 1'b0;
        for (int c = 0; c < 8*N && (acc < 4*N || exp_q.size() > 0); c++) begin
            do_cycle(acc < 4*N, DATA_W'($urandom), 1'b1, 1'b0, rdy, ov, od, osof, oeof);
            if (acc < 4*N) begin
                n_cmp++;
                if (rdy !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand_in_ready[%0d]: got %b required 1", acc, rdy);
                end
                if (rdy) acc++;
            end
            if (ov) begin
                started = 1'b1;
                e = exp_q.pop_front();
                n_cmp++;
                if ({od, osof, oeof} !== {e.d, e.sof, e.eof}) begin
                    n_err++;
                    $display("FAIL rand_out: got %h sof=%b eof=%b required %h sof=%b eof=%b",
                             od, osof, oeof, e.d, e.sof, e.eof);
                end
            end else if (started && exp_q.size() > 0) begin
                gaps++;
            end
        end
        n_cmp++;
        if (gaps != 0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_stream: got %0d gaps %0d pending required 0/0", gaps, exp_q.size());
        end
    endtask

    task automatic test_clr();
        logic rdy, ov, osof, oeof;
        logic [DATA_W-1:0] od;
        exp_t e;
        int acc = 0;
        int outs = 0;
        for (int c = 0; c < 4*N && acc < N + 100; c++) begin
            do_cycle(1'b1, (acc < N) ? DATA_W'(acc) : DATA_W'($urandom), 1'b1, 1'b0,
                     rdy, ov, od, osof, oeof);
            if (rdy) acc++;
            if (ov) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({od, osof, oeof} !== {e.d, e.sof, e.eof}) begin
                    n_err++;
                    $display("FAIL clr_pre_out: got %h required %h", od, e.d);
                end
            end
        end
        n_cmp++;
        if (ov !== 1'b1) begin
            n_err++;
            $display("FAIL clr_pre_streaming: got valid=%b required 1", ov);
        end
        do_cycle(1'b0, '0, 1'b1, 1'b1, rdy, ov, od, osof, oeof);
        do_cycle(1'b0, '0, 1'b1, 1'b0, rdy, ov, od, osof, oeof);
        n_cmp++;
        if (ov !== 1'b0 || rdy !== 1'b1 || od !== '0 || osof !== 1'b0 || oeof !== 1'b0) begin
            n_err++;
            $display("FAIL clr_flush: got valid=%b ready=%b data=%h sof=%b eof=%b required 0/1/0/0/0",
                     ov, rdy, od, osof, oeof);
        end
        acc = 0;
        for (int c = 0; c < 6*N && (acc < N || exp_q.size() > 0); c++) begin
            do_cycle(acc < N, DATA_W'(acc), 1'b1, 1'b0, rdy, ov, od, osof, oeof);
            if (acc < N && rdy) acc++;
            if (ov) begin
                if (outs == 0) begin
                    n_cmp++;
                    if (osof !== 1'b1 || od !== '0) begin
                        n_err++;
                        $display("FAIL clr_first: got sof=%b data=%h required 1/0", osof, od);
                    end
                end
                e = exp_q.pop_front();
                n_cmp++;
                if ({od, osof, oeof} !== {e.d, e.sof, e.eof}) begin
                    n_err++;
                    $display("FAIL clr_post_out[%0d]: got %h sof=%b eof=%b required %h sof=%b eof=%b",
                             outs, od, osof, oeof, e.d, e.sof, e.eof);
                end
                outs++;
            end
        end
        do_cycle(1'b0, '0, 1'b1, 1'b0, rdy, ov, od, osof, oeof);
        n_cmp++;
        if (outs != N || ov !== 1'b0) begin
            n_err++;
            $display("FAIL clr_post_count: got %0d outputs trailing valid=%b required %0d/0", outs, ov, N);
        end
    endtask

    task automatic test_async_reset();
        logic rdy, ov, osof, oeof;
        logic [DATA_W-1:0] od;
        int acc = 0;
        for (int c = 0; c < 3*N && (acc < N || !ov); c++) begin
            do_cycle(acc < N, DATA_W'($urandom) | 1, 1'b0, 1'b0, rdy, ov, od, osof, oeof);
            if (acc < N && rdy) acc++;
        end
        @(posedge clock_c);
        #2;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data === '0) begin
            n_err++;
            $display("FAIL areset_pre: got valid=%b data=%h required 1/nonzero", bus.out_valid, bus.out_data);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.out_valid, bus.out_sof, bus.out_eof} !== 3'b000 || bus.out_data !== '0) begin
            n_err++;
            $display("FAIL areset_immediate: got v/sof/eof=%b%b%b data=%h required 000/0",
                     bus.out_valid, bus.out_sof, bus.out_eof, bus.out_data);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        @(negedge clock_c);
        reset_n = 1'b1;
        @(negedge clock_c);
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL areset_release: got ready=%b valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clock_c);
        test_reset();
        test_ramp();
        test_backpressure();
        test_toggle();
        test_random_frames();
        test_clr();
        test_async_reset();
        test_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cf_fft_reorder_pingpong_rd.md
Name: cf_fft_reorder_pingpong_rd

Overview:
- Double-buffered (ping-pong) frame reorder buffer on the FFT input side.
- Accepts samples in natural order on a valid/ready stream and writes them sequentially into one of two banks.
- Reads each completed frame out of the other bank in bit-reversed address order, so the next radix-2 stage receives its data already permuted.
- It is the read-side permuting counterpart to the write-side-scattered, sequential-read output reorder buffer already in the FFT path.

Parameters:
- DATA_W, 32, sample width (packed re/im).
- ADDR_W, 8, log2 of frame length; N = 2^ADDR_W words per bank.

Ports:
- clock_c  input  1  single clock, all state on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; same effect as reset, excluding memory contents.
- in_valid  input  1  input sample valid.
- in_data  input  DATA_W  input sample.
- in_ready  output  1  buffer can accept in_data this cycle.
- out_valid  output  1  out_data holds a valid sample.
- out_data  output  DATA_W  reordered sample.
- out_ready  input  1  downstream accepts out_data.
- out_sof  output  1  out_data is the first sample of a frame.
- out_eof  output  1  out_data is the last sample of a frame.

Behaviour:
- Storage:
  - Two banks of N x DATA_W, not reset.
  - Per-bank full flag full[1:0].
  - Write pointer wr_bank, write counter wr_cnt (ADDR_W bits).
  - Read pointer rd_bank, read counter rd_cnt (ADDR_W bits).
- Reset (reset_n low, immediate) and clr (next edge, priority over all other activity):
  - wr_cnt, rd_cnt, wr_bank, rd_bank, full all 0.
  - out_valid=0, out_data=0, out_sof=0, out_eof=0.
  - in_ready=1 after release.
- Write side:
  - in_ready = ~full[wr_bank], combinational.
  - Accept when in_valid & in_ready: bank[wr_bank][wr_cnt] <= in_data, then wr_cnt++ (wraps at N).
  - On accepting wr_cnt==N-1: set full[wr_bank] and toggle wr_bank.
  - With both banks full, in_ready=0 until a read frame completes.
- Read side, single registered output stage:
  - Load condition: full[rd_bank] & (~out_valid | out_ready).
  - On load:
    - out_data <= bank[rd_bank][raddr], with raddr = bitrev(rd_cnt), combinational array read.
    - out_valid <= 1; out_sof <= (rd_cnt==0); out_eof <= (rd_cnt==N-1).
    - rd_cnt++.
  - Loading rd_cnt==N-1: clear full[rd_bank] and toggle rd_bank.
  - If out_valid & out_ready and no load: out_valid <= 0, sof/eof <= 0.
  - While out_valid & ~out_ready: out_data, out_sof, out_eof held stable.
- Latency: out_valid rises on the edge after the edge that accepts sample N-1 of a frame.
- Throughput: 1 sample/cycle sustained in both directions with out_ready=1; in_ready never drops in steady state.
- Simultaneous events:
  - Write-frame completion and read-frame completion in the same cycle update different banks' flags; both take effect.
  - A bank cannot be written and read concurrently: writes require full=0, reads require full=1.
- A partial frame stays in the write bank until completed or cleared. No timeout.

Optional Feature:
- Macro: CF_FFT_REORDER_BITREV_EN.
- Defined: raddr = bit-reverse of rd_cnt over ADDR_W bits.
- Undefined: raddr = rd_cnt. The block is a plain natural-order ping-pong FIFO with identical handshake, latency and sof/eof.

Test Plan:
- Macro defined, ADDR_W=8, ramp 0..255 written continuously, out_ready=1 -> out_valid rises 1 cycle after sample 255 is accepted. Outputs are 0,128,64,192,...,255. out_sof on 0, out_eof on 255.
- out_ready=0, stream 3 frames -> in_ready drops after exactly 512 accepts. Raising out_ready drains frame 0 then frame 1. in_ready returns 1 the cycle after frame-0 read completes.
- out_ready toggled 1,0,1,0 every cycle across a frame -> 256 unique outputs, no drops or duplicates. out_data/sof/eof stable while valid & ~ready.
- Continuous random data, 4 frames, in_valid=out_ready=1 -> in_ready constantly 1. Each output frame equals the bit-reversed permutation of its input frame.
- clr pulsed after 100 writes of frame 1 while frame 0 is streaming out -> next cycle out_valid=0, in_ready=1. A following full ramp frame appears first with out_sof and value 0.
- reset_n driven low mid-stream asynchronously -> out_valid/out_data/sof/eof go to 0 without a clock edge. Macro undefined: ramp 0..255 is output as 0,1,2,...,255.
